alu_sequencer: RTL and testbench

- Command-side controller that drives the team's combinational ALU (BITWIDTH operands, 5-bit ALUop, overflow/zero/sign flags).
- Accepts accumulator-style commands over a valid/ready stream and presents registered operands and opcode to the ALU.
- Captures the ALU result into an accumulator and returns result plus flags over a second valid/ready stream.
- Sits between an instruction source (testbench, microcontroller, DMA script engine) and one ALU instance.

---
 rtl/alu_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Accumulator-style command sequencer feeding one combinational ALU and returning results with flags.
// Optional sticky overflow flag (stickyOvf/ovfClear) is enabled by defining ALUSEQ_STICKY_OVF_EN.
module alu_sequencer #(
   parameter int BITWIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmdValid,
   output logic                cmdReady,
   input  logic                cmdLoad,
   input  logic [4:0]          cmdOp,
   input  logic [BITWIDTH-1:0] cmdData,
   output logic [BITWIDTH-1:0] aluOpA,
   output logic [BITWIDTH-1:0] aluOpB,
   output logic [4:0]          aluOp,
   input  logic [BITWIDTH-1:0] aluResult,
   input  logic                aluOverflow,
   input  logic                aluZero,
   input  logic                aluSign,
   output logic                resValid,
   input  logic                resReady,
   output logic [BITWIDTH-1:0] resData,
   output logic [2:0]          resFlags,
   output logic [BITWIDTH-1:0] acc
`ifdef ALUSEQ_STICKY_OVF_EN
   ,
   output logic                stickyOvf,
   input  logic                ovfClear
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_r;
   logic                cmd_ready_r;
   logic                res_valid_r;
   logic [BITWIDTH-1:0] acc_r;
   logic [BITWIDTH-1:0] opa_r;
   logic [BITWIDTH-1:0] opb_r;
   logic [4:0]          op_r;
   logic [BITWIDTH-1:0] res_data_r;
   logic [2:0]          res_flags_r;

   // Command/result FSM; handshake flags are registered alongside the state so they never glitch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cmd_ready_r <= 1'b1;
         res_valid_r <= 1'b0;
         acc_r       <= {BITWIDTH{1'b0}};
         opa_r       <= {BITWIDTH{1'b0}};
         opb_r       <= {BITWIDTH{1'b0}};
         op_r        <= 5'd0;
         res_data_r  <= {BITWIDTH{1'b0}};
         res_flags_r <= 3'b000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmdValid) begin
                  if (cmdLoad) begin
                     acc_r <= cmdData;
                  end else begin
                     opa_r       <= acc_r;
                     opb_r       <= cmdData;
                     op_r        <= cmdOp;
                     cmd_ready_r <= 1'b0;
                     state_r     <= ST_EXEC;
                  end
               end else begin
                  cmd_ready_r <= 1'b1;
               end
            end
            ST_EXEC: begin
               // ALU has had a full cycle to settle on the registered operands.
               acc_r       <= aluResult;
               res_data_r  <= aluResult;
               res_flags_r <= {aluOverflow, aluZero, aluSign};
               res_valid_r <= 1'b1;
               state_r     <= ST_RESP;
            end
            ST_RESP: begin
               if (resReady) begin
                  res_valid_r <= 1'b0;
                  cmd_ready_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  res_valid_r <= 1'b1;
               end
            end
            default: begin
               res_valid_r <= 1'b0;
               cmd_ready_r <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ALUSEQ_STICKY_OVF_EN
   logic sticky_ovf_r;

   // Sticky overflow: a set at the EXEC edge takes priority over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_ovf_r <= 1'b0;
      end else if ((state_r == ST_EXEC) && aluOverflow) begin
         sticky_ovf_r <= 1'b1;
      end else if (ovfClear) begin
         sticky_ovf_r <= 1'b0;
      end else begin
         sticky_ovf_r <= sticky_ovf_r;
      end
   end

   assign stickyOvf = sticky_ovf_r;
`endif

   assign cmdReady = cmd_ready_r;
   assign resValid = res_valid_r;
   assign acc      = acc_r;
   assign aluOpA   = opa_r;
   assign aluOpB   = opb_r;
   assign aluOp    = op_r;
   assign resData  = res_data_r;
   assign resFlags = res_flags_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU; define ALUSEQ_STICKY_OVF_EN to cover stickyOvf.
module tb_alu_sequencer;

   localparam int BW = 8;
   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_INCA  = 5'd2;
   localparam logic [4:0] OP_DECA  = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_SHLA2 = 5'd5;
   localparam logic [4:0] OP_BAD   = 5'd31;

   logic          clk;
   logic          rst_n;
   logic          cmdValid;
   logic          cmdReady;
   logic          cmdLoad;
   logic [4:0]    cmdOp;
   logic [BW-1:0] cmdData;
   logic [BW-1:0] aluOpA;
   logic [BW-1:0] aluOpB;
   logic [4:0]    aluOp;
   logic [BW-1:0] aluResult;
   logic          aluOverflow;
   logic          aluZero;
   logic          aluSign;
   logic          resValid;
   logic          resReady;
   logic [BW-1:0] resData;
   logic [2:0]    resFlags;
   logic [BW-1:0] acc;
`ifdef ALUSEQ_STICKY_OVF_EN
   logic          stickyOvf;
   logic          ovfClear;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_sequencer #(.BITWIDTH(BW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdLoad(cmdLoad), .cmdOp(cmdOp), .cmdData(cmdData),
      .aluOpA(aluOpA), .aluOpB(aluOpB), .aluOp(aluOp),
      .aluResult(aluResult), .aluOverflow(aluOverflow), .aluZero(aluZero), .aluSign(aluSign),
      .resValid(resValid), .resReady(resReady), .resData(resData), .resFlags(resFlags), .acc(acc)
`ifdef ALUSEQ_STICKY_OVF_EN
      , .stickyOvf(stickyOvf), .ovfClear(ovfClear)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: overflow is carry/borrow out (bits lost for SHLA2).
   logic [BW:0] wide;
   always_comb begin
      wide = {(BW+1){1'b0}};
      aluOverflow = 1'b0;
      case (aluOp)
         OP_ADD:   begin wide = {1'b0, aluOpA} + {1'b0, aluOpB}; aluOverflow = wide[BW]; end
         OP_SUB:   begin wide = {1'b0, aluOpA} - {1'b0, aluOpB}; aluOverflow = wide[BW]; end
         OP_INCA:  begin wide = {1'b0, aluOpA} + 9'd1;           aluOverflow = wide[BW]; end
         OP_DECA:  begin wide = {1'b0, aluOpA} - 9'd1;           aluOverflow = wide[BW]; end
         OP_XOR:   begin wide = {1'b0, aluOpA ^ aluOpB}; end
         OP_SHLA2: begin wide = {1'b0, aluOpA << 2};     aluOverflow = |aluOpA[BW-1:BW-2]; end
         default:  begin wide = {(BW+1){1'b0}}; end
      endcase
      aluResult = wide[BW-1:0];
      aluZero   = (aluResult == {BW{1'b0}});
      aluSign   = aluResult[BW-1];
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic do_load(input logic [BW-1:0] val);
      @(negedge clk);
      cmdValid = 1'b1; cmdLoad = 1'b1; cmdOp = 5'd0; cmdData = val;
      @(posedge clk);
      @(negedge clk);
      cmdValid = 1'b0; cmdLoad = 1'b0;
      chk("load_acc", {8'h00, acc}, {8'h00, val});
      chk("load_ready", {15'd0, cmdReady}, 16'd1);
   endtask

   // ALU op with resReady high: checks latency, result, flags and return to IDLE.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [BW-1:0] data,
                         input logic [BW-1:0] exp_res, input logic [2:0] exp_flg);
      @(negedge clk);
      resReady = 1'b1;
      cmdValid = 1'b1; cmdLoad = 1'b0; cmdOp = op; cmdData = data;
      @(posedge clk);
      @(negedge clk);
      cmdValid = 1'b0;
      chk({tag, "_exec_valid"}, {15'd0, resValid}, 16'd0);
      chk({tag, "_exec_ready"}, {15'd0, cmdReady}, 16'd0);
      chk({tag, "_aluop"}, {11'd0, aluOp}, {11'd0, op});
      chk({tag, "_opb"}, {8'h00, aluOpB}, {8'h00, data});
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_valid"}, {15'd0, resValid}, 16'd1);
      chk({tag, "_data"}, {8'h00, resData}, {8'h00, exp_res});
      chk({tag, "_flags"}, {13'd0, resFlags}, {13'd0, exp_flg});
      chk({tag, "_acc"}, {8'h00, acc}, {8'h00, exp_res});
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_idle_valid"}, {15'd0, resValid}, 16'd0);
      chk({tag, "_idle_ready"}, {15'd0, cmdReady}, 16'd1);
   endtask

   initial begin
      rst_n = 1'b0; cmdValid = 1'b0; cmdLoad = 1'b0; cmdOp = 5'd0; cmdData = 8'h00; resReady = 1'b1;
`ifdef ALUSEQ_STICKY_OVF_EN
      ovfClear = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {15'd0, cmdReady}, 16'd1);
      chk("rst_valid", {15'd0, resValid}, 16'd0);
      chk("rst_acc", {8'h00, acc}, 16'h0000);
      chk("rst_opa", {8'h00, aluOpA}, 16'h0000);
      chk("rst_opb", {8'h00, aluOpB}, 16'h0000);
      chk("rst_aluop", {11'd0, aluOp}, 16'h0000);
      chk("rst_data", {8'h00, resData}, 16'h0000);
      chk("rst_flags", {13'd0, resFlags}, 16'h0000);
      rst_n = 1'b1;

      do_load(8'h7F);
      run_op("add", OP_ADD, 8'h01, 8'h80, 3'b001);
      chk("add_opa", {8'h00, aluOpA}, 16'h007F);

      do_load(8'hFF);
      run_op("inca", OP_INCA, 8'h00, 8'h00, 3'b110);

      // Backpressure: result held, cmd pulse ignored while in RESP.
      do_load(8'hF0);
      @(negedge clk);
      resReady = 1'b0;
      cmdValid = 1'b1; cmdLoad = 1'b0; cmdOp = OP_XOR; cmdData = 8'h0F;
      @(posedge clk);
      @(negedge clk);
      cmdValid = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", {15'd0, resValid}, 16'd1);
         chk("bp_data", {8'h00, resData}, 16'h00FF);
         chk("bp_flags", {13'd0, resFlags}, 16'h0001);
         chk("bp_ready", {15'd0, cmdReady}, 16'd0);
         if (i == 1) begin
            cmdValid = 1'b1; cmdLoad = 1'b1; cmdData = 8'h12;
         end else begin
            cmdValid = 1'b0; cmdLoad = 1'b0;
         end
         @(posedge clk);
      end
      @(negedge clk);
      cmdValid = 1'b0; cmdLoad = 1'b0;
      chk("bp_acc_kept", {8'h00, acc}, 16'h00FF);
      resReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_valid", {15'd0, resValid}, 16'd0);
      chk("bp_release_ready", {15'd0, cmdReady}, 16'd1);
      chk("bp_release_acc", {8'h00, acc}, 16'h00FF);

      do_load(8'h05);
      run_op("sub", OP_SUB, 8'h06, 8'hFF, 3'b101);
      run_op("shla2", OP_SHLA2, 8'h00, 8'hFC, 3'b101);
      run_op("badop", OP_BAD, 8'h33, 8'h00, 3'b010);

      // Reset while a result is pending.
      @(negedge clk);
      resReady = 1'b0;
      cmdValid = 1'b1; cmdLoad = 1'b0; cmdOp = OP_ADD; cmdData = 8'h01;
      @(posedge clk);
      @(negedge clk);
      cmdValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_resp_valid", {15'd0, resValid}, 16'd1);
      chk("mid_resp_acc", {8'h00, acc}, 16'h0001);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", {15'd0, resValid}, 16'd0);
      chk("rst_resp_acc", {8'h00, acc}, 16'h0000);
      chk("rst_resp_ready", {15'd0, cmdReady}, 16'd1);
      chk("rst_resp_data", {8'h00, resData}, 16'h0000);
      rst_n = 1'b1;
      resReady = 1'b1;

`ifdef ALUSEQ_STICKY_OVF_EN
      chk("sticky_rst", {15'd0, stickyOvf}, 16'd0);
      do_load(8'h00);
      run_op("deca", OP_DECA, 8'h00, 8'hFF, 3'b101);
      chk("sticky_set", {15'd0, stickyOvf}, 16'd1);
      run_op("add0", OP_ADD, 8'h00, 8'hFF, 3'b001);
      chk("sticky_persist", {15'd0, stickyOvf}, 16'd1);
      @(negedge clk);
      ovfClear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ovfClear = 1'b0;
      chk("sticky_clear", {15'd0, stickyOvf}, 16'd0);
      do_load(8'hFF);
      @(negedge clk);
      cmdValid = 1'b1; cmdLoad = 1'b0; cmdOp = OP_INCA; cmdData = 8'h00;
      @(posedge clk);
      @(negedge clk);
      cmdValid = 1'b0;
      ovfClear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ovfClear = 1'b0;
      chk("sticky_set_wins", {15'd0, stickyOvf}, 16'd1);
      chk("sticky_inca_flags", {13'd0, resFlags}, 16'h0006);
      @(posedge clk);
      @(negedge clk);
      chk("sticky_idle", {15'd0, cmdReady}, 16'd1);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
